// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a word-addressed DataMemory.
// Sub-word stores become a read-modify-write because the memory only writes whole words.
//
// state     | meaning
// IDLE      | ready; misaligned/illegal requests are answered without leaving IDLE
// LOAD      | MemRead high; lane extracted, extended and registered at the edge
// STORE     | MemWrite high with the latched full word
// RMW_READ  | MemRead high; target lane replaced and captured into mergeReg
// RMW_WRITE | MemWrite high with mergeReg
module load_store_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  misaligned_err,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  MemWrite,
    output logic                  MemRead,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE,
        RMW_READ,
        RMW_WRITE
    } stateType;

    stateType state, nextState;

    logic [DATA_WIDTH-1:0] latAddr;
    logic [DATA_WIDTH-1:0] latWdata;
    logic [1:0]            latSize;
    logic                  latUnsigned;
    logic [DATA_WIDTH-1:0] mergeReg;
    logic                  errPending;

    logic                  accept;
    logic                  reqErr;
    logic [7:0]            loadByte;
    logic [15:0]           loadHalf;
    logic [DATA_WIDTH-1:0] loadExt;
    logic [DATA_WIDTH-1:0] mergeNext;

    assign accept   = req_valid && req_ready;
    assign mem_addr = {latAddr[DATA_WIDTH-1:2], 2'b00};

    always_comb begin
        reqErr = 1'b0;
        case (req_size)
            SIZE_HALF: reqErr = req_addr[0];
            SIZE_WORD: reqErr = |req_addr[1:0];
            2'b11:     reqErr = 1'b1;
            default:   reqErr = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        req_ready = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (accept && !reqErr) begin
                    if (!req_write) begin
                        nextState = LOAD;
                    end else if (req_size == SIZE_WORD) begin
                        nextState = STORE;
                    end else begin
                        nextState = RMW_READ;
                    end
                end
            end
            LOAD: begin
                MemRead   = 1'b1;
                nextState = IDLE;
            end
            STORE: begin
                MemWrite  = 1'b1;
                mem_wdata = latWdata;
                nextState = IDLE;
            end
            RMW_READ: begin
                MemRead   = 1'b1;
                nextState = RMW_WRITE;
            end
            RMW_WRITE: begin
                MemWrite  = 1'b1;
                mem_wdata = mergeReg;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        loadByte = mem_rdata[7:0];
        case (latAddr[1:0])
            2'd1:    loadByte = mem_rdata[15:8];
            2'd2:    loadByte = mem_rdata[23:16];
            2'd3:    loadByte = mem_rdata[31:24];
            default: loadByte = mem_rdata[7:0];
        endcase
        loadHalf = latAddr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (latSize)
            SIZE_BYTE: loadExt = latUnsigned ? {{(DATA_WIDTH-8){1'b0}}, loadByte}
                                             : {{(DATA_WIDTH-8){loadByte[7]}}, loadByte};
            SIZE_HALF: loadExt = latUnsigned ? {{(DATA_WIDTH-16){1'b0}}, loadHalf}
                                             : {{(DATA_WIDTH-16){loadHalf[15]}}, loadHalf};
            default:   loadExt = mem_rdata;
        endcase
    end

    // Replace only the addressed lane of the word just read.
    always_comb begin
        mergeNext = mem_rdata;
        if (latSize == SIZE_BYTE) begin
            case (latAddr[1:0])
                2'd0:    mergeNext[7:0]   = latWdata[7:0];
                2'd1:    mergeNext[15:8]  = latWdata[7:0];
                2'd2:    mergeNext[23:16] = latWdata[7:0];
                default: mergeNext[31:24] = latWdata[7:0];
            endcase
        end else if (latAddr[1]) begin
            mergeNext[31:16] = latWdata[15:0];
        end else begin
            mergeNext[15:0] = latWdata[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            latAddr        <= '0;
            latWdata       <= '0;
            latSize        <= '0;
            latUnsigned    <= 1'b0;
            mergeReg       <= '0;
            errPending     <= 1'b0;
            resp_valid     <= 1'b0;
            misaligned_err <= 1'b0;
            resp_rdata     <= '0;
        end else begin
            resp_valid     <= 1'b0;
            misaligned_err <= 1'b0;
            resp_rdata     <= '0;
            errPending     <= 1'b0;
            if (accept) begin
                latAddr     <= req_addr;
                latWdata    <= req_wdata;
                latSize     <= req_size;
                latUnsigned <= req_unsigned;
                errPending  <= reqErr;
            end
            // A rejected request answers one edge after accept, like a load.
            if (errPending) begin
                resp_valid     <= 1'b1;
                misaligned_err <= 1'b1;
            end
            case (state)
                LOAD: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= loadExt;
                end
                STORE, RMW_WRITE: resp_valid <= 1'b1;
                RMW_READ:         mergeReg   <= mergeNext;
                default:          ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random requests
// compared against a word-array reference model with arithmetic lane handling.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, misaligned_err, MemWrite, MemRead;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

    logic [31:0] dmem   [0:63];
    logic [31:0] refMem [0:63];
    logic        loadEn;
    logic [5:0]  loadIdx;
    logic [31:0] loadVal;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .misaligned_err (misaligned_err),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .MemWrite       (MemWrite),
        .MemRead        (MemRead),
        .mem_rdata      (mem_rdata)
    );

    // DataMemory stand-in: combinational read gated by MemRead, write on the rising edge.
    assign mem_rdata = MemRead ? dmem[mem_addr[7:2]] : 32'h0;

    always @(posedge clk) begin
        if (loadEn) dmem[loadIdx] <= loadVal;
        else if (MemWrite) dmem[mem_addr[7:2]] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] refLoad(input logic [31:0] w, input logic [1:0] sz,
                                            input logic uns, input int off);
        int unsigned v;
        if (sz == 2'b10) return w;
        if (sz == 2'b00) begin
            v = (w >> (8 * off)) % 256;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else begin
            v = (w >> (16 * (off / 2))) % 65536;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] refStore(input logic [31:0] w, input logic [1:0] sz,
                                             input int off, input logic [31:0] wd);
        int unsigned sh, lane;
        if (sz == 2'b00) begin
            sh = 8 * off;
            lane = 255;
        end else begin
            sh = 16 * (off / 2);
            lane = 65535;
        end
        return w - (w & (lane << sh)) + ((wd & lane) << sh);
    endfunction

    // Issue one request from IDLE and observe five cycles after the accept edge.
    task automatic doReq(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input logic hold);
        int idx, off, expLat, expRd, expWr, lat, rdCnt, wrCnt, both, respCnt;
        logic expErr, gotErr;
        logic [31:0] expWord, expRdata, gotRdata, wrAddr, wrData;
        idx = int'(a[7:2]);
        off = int'(a[1:0]);
        expErr = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && off != 0);
        expWord = refMem[idx];
        expRdata = 32'h0;
        expLat = 2;
        expRd = 0;
        expWr = 0;
        if (expErr) begin
            expLat = 2;
        end else if (!wr) begin
            expRd = 1;
            expRdata = refLoad(refMem[idx], sz, uns, off);
        end else if (sz == 2'b10) begin
            expWr = 1;
            expWord = wd;
        end else begin
            expLat = 3;
            expRd = 1;
            expWr = 1;
            expWord = refStore(refMem[idx], sz, off, wd);
        end

        check("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_size = sz;
        req_unsigned = uns;
        req_addr = a;
        req_wdata = wd;
        @(posedge clk);
        lat = 0; rdCnt = 0; wrCnt = 0; both = 0; respCnt = 0;
        gotErr = 1'b0; gotRdata = 32'h0; wrAddr = 32'h0; wrData = 32'h0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (MemRead) rdCnt++;
            if (MemWrite) begin
                wrCnt++;
                wrAddr = mem_addr;
                wrData = mem_wdata;
            end
            if (MemRead && MemWrite) both++;
            if (resp_valid) begin
                respCnt++;
                if (lat == 0) begin
                    lat = c;
                    gotErr = misaligned_err;
                    gotRdata = resp_rdata;
                end
            end
            if (!hold || expErr || lat != 0) req_valid = 1'b0;
        end

        check("resp_latency", 32'(lat), 32'(expLat));
        check("resp_count", 32'(respCnt), 32'd1);
        check("misaligned_err", 32'(gotErr), 32'(expErr));
        check("resp_rdata", gotRdata, expRdata);
        check("memread_cycles", 32'(rdCnt), 32'(expRd));
        check("memwrite_cycles", 32'(wrCnt), 32'(expWr));
        check("rd_wr_overlap", 32'(both), 32'd0);
        if (expWr != 0) begin
            check("write_addr", wrAddr, {a[31:2], 2'b00});
            check("write_data", wrData, expWord);
        end
        check("mem_word", dmem[idx], expWord);
        refMem[idx] = expWord;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int strobes;
        reset = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size = 2'b00;
        req_unsigned = 1'b0;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        loadEn = 1'b0;
        loadIdx = 6'd0;
        loadVal = 32'h0;

        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_misaligned", 32'(misaligned_err), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_memwrite", 32'(MemWrite), 32'd0);
        check("rst_memread", 32'(MemRead), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);

        // Preload memory while a word store is presented; reset must ignore it.
        strobes = 0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size = 2'b10;
        req_addr = 32'h1001_0000;
        req_wdata = 32'h5555_5555;
        for (int i = 0; i < 64; i++) begin
            refMem[i] = (i == 1) ? 32'h8899_AABB : $urandom;
            loadEn = 1'b1;
            loadIdx = 6'(i);
            loadVal = refMem[i];
            @(negedge clk);
            if (MemRead || MemWrite || resp_valid) strobes++;
        end
        loadEn = 1'b0;
        req_valid = 1'b0;
        check("ignored_in_reset", 32'(strobes), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        doReq(1'b0, 2'b00, 1'b0, 32'h1001_0005, 32'h0, 1'b0);
        check("lb_value", refLoad(refMem[1], 2'b00, 1'b0, 1), 32'hFFFF_FFAA);
        doReq(1'b0, 2'b00, 1'b1, 32'h1001_0005, 32'h0, 1'b0);
        doReq(1'b0, 2'b01, 1'b0, 32'h1001_0006, 32'h0, 1'b0);
        doReq(1'b0, 2'b01, 1'b1, 32'h1001_0006, 32'h0, 1'b0);
        doReq(1'b1, 2'b00, 1'b0, 32'h1001_0007, 32'h0000_0011, 1'b0);
        check("sb_word", dmem[1], 32'h1199_AABB);

        // Word store followed by a load accepted in the response cycle.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size = 2'b10;
        req_unsigned = 1'b0;
        req_addr = 32'h1001_0008;
        req_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        check("b2b_ready_store", 32'(req_ready), 32'd0);
        check("b2b_memwrite", 32'(MemWrite), 32'd1);
        req_valid = 1'b0;
        @(negedge clk);
        check("b2b_sw_resp", 32'(resp_valid), 32'd1);
        check("b2b_ready_resp", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = 1'b0;
        @(negedge clk);
        check("b2b_ready_load", 32'(req_ready), 32'd0);
        check("b2b_memread", 32'(MemRead), 32'd1);
        req_valid = 1'b0;
        @(negedge clk);
        check("b2b_lw_resp", 32'(resp_valid), 32'd1);
        check("b2b_lw_rdata", resp_rdata, 32'hDEAD_BEEF);
        refMem[2] = 32'hDEAD_BEEF;
        @(negedge clk);
        check("b2b_resp_done", 32'(resp_valid), 32'd0);

        doReq(1'b1, 2'b01, 1'b0, 32'h1001_0005, 32'h1234_5678, 1'b0);
        doReq(1'b0, 2'b10, 1'b0, 32'h1001_0002, 32'h0, 1'b0);
        doReq(1'b0, 2'b11, 1'b0, 32'h1001_0004, 32'h0, 1'b0);
        doReq(1'b1, 2'b11, 1'b0, 32'h1001_0004, 32'hFFFF_FFFF, 1'b0);

        doReq(1'b1, 2'b10, 1'b0, 32'h1001_0010, $urandom, 1'b1);
        doReq(1'b1, 2'b00, 1'b0, 32'h1001_0011, $urandom, 1'b1);
        doReq(1'b1, 2'b01, 1'b0, 32'h1001_0016, $urandom, 1'b1);

        // Reset during RMW_WRITE must abort the write.
        doReq(1'b1, 2'b10, 1'b0, 32'h1001_0004, 32'h8899_AABB, 1'b0);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size = 2'b00;
        req_addr = 32'h1001_0004;
        req_wdata = 32'h0000_0077;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_rmw_read", 32'(MemRead), 32'd1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("abort_memwrite", 32'(MemWrite), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd1);
        check("abort_resp", 32'(resp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        strobes = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (resp_valid || MemWrite) strobes++;
        end
        check("abort_quiet", 32'(strobes), 32'd0);
        check("abort_word", dmem[1], 32'h8899_AABB);

        for (int n = 0; n < 60; n++) begin
            doReq(1'($urandom % 2), 2'($urandom % 4), 1'($urandom % 2),
                  32'h1001_0000 + 32'($urandom_range(0, 255)), $urandom, 1'($urandom % 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the MEM pipeline stage and the word-addressed `DataMemory`. It accepts byte, halfword and word loads and stores at byte addresses and checks alignment. Sub-word loads are sign- or zero-extended. Sub-word stores become a two-cycle read-modify-write, because `DataMemory` only writes whole words. The pipeline stalls while `req_ready` is low. Memory-side outputs connect directly to `DataMemory` (`Address`, `WriteData`, `MemWrite`, `MemRead`, `ReadData`).

## Interface
- `DATA_WIDTH`, 32, data and address width (the block is defined for 32 only).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `req_valid`  in  1  request present; accepted on an edge where `req_valid & req_ready`.
- `req_ready`  out  1  high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_unsigned`  in  1  zero-extend sub-word loads (lbu/lhu).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load result; 0 for stores and errors.
- `misaligned_err`  out  1  valid with `resp_valid`; request was misaligned or illegal.
- `mem_addr`  out  32  `{addr[31:2],2'b00}` of the latched request.
- `mem_wdata`  out  32  full word to write.
- `MemWrite`  out  1  write strobe to `DataMemory`.
- `MemRead`  out  1  read enable to `DataMemory`.
- `mem_rdata`  in  32  `DataMemory` `ReadData` (combinational, gated by `MemRead`).

## Operation
- Byte lanes are little-endian: `addr[1:0]`=0 selects bits [7:0] and 3 selects [31:24]. A halfword at `addr[1]`=0 is [15:0], at 1 is [31:16].
- On accept, latch addr, size, unsigned, write and wdata.
- Alignment is checked on accept:
  - The request is in error if size=11, or half with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - An error performs no memory access and the FSM stays in IDLE.
  - On the next edge `resp_valid`=1, `misaligned_err`=1 and `resp_rdata`=0.
- FSM states: IDLE, LOAD, STORE, RMW_READ, RMW_WRITE.
  - IDLE: the next state depends on the accepted request:
    - load → LOAD.
    - word store → STORE.
    - byte or half store → RMW_READ.
    - error or no accept → IDLE.
  - LOAD: `MemRead`=1. At the edge, extract the lane, extend it, register it into `resp_rdata`, then go to IDLE.
  - STORE: `MemWrite`=1, `mem_wdata`=latched wdata, then go to IDLE.
  - RMW_READ: `MemRead`=1. At the edge, capture `mem_rdata`, replace the target lane with `wdata[7:0]` or `wdata[15:0]`, store the result into the merge register, then go to RMW_WRITE.
  - RMW_WRITE: `MemWrite`=1, `mem_wdata`=merge register, then go to IDLE.
- Leaving LOAD, STORE or RMW_WRITE registers `resp_valid`=1 and `misaligned_err`=0 for exactly one cycle.
- `MemRead` and `MemWrite` are never high together. Both are low in IDLE.
- Requests presented while `req_ready`=0 are ignored and are not queued.

## Timing
- Edge 0 is the accept edge.
- Load: LOAD cycle runs between edges 0 and 1; `resp_valid` is high between edges 1 and 2.
- Word store: `DataMemory` writes at edge 1; `resp_valid` is high between edges 1 and 2.
- Sub-word store: read at edge 1, write at edge 2; `resp_valid` is high between edges 2 and 3.
- Error: `resp_valid` is high between edges 1 and 2.
- Back-to-back: `req_ready` returns high in the same cycle as `resp_valid`, so a new request may be accepted at the edge that ends the `resp_valid` cycle.
- Reset values (during and after reset):
  - state IDLE, so `req_ready`=1; requests are ignored while `reset`=0.
  - `resp_valid`=0, `misaligned_err`=0, `resp_rdata`=0.
  - `MemWrite`=0, `MemRead`=0, `mem_addr`=0, `mem_wdata`=0.
  - merge and latch registers cleared.
- Reset mid-operation aborts the transaction, with no response:
  - Reset asserted in RMW_READ or RMW_WRITE before the write edge: memory is not modified.
  - Reset asserted in STORE before the edge: the write does not occur, because `MemWrite` drops asynchronously.

## Test plan
- Preload word 0x1001_0004 = 0x8899_AABB.
  - lb 0x1001_0005 → `resp_rdata`=0xFFFF_FFAA one cycle after accept; `MemRead` high for exactly 1 cycle.
  - lbu → 0x0000_00AA.
  - lh 0x1001_0006 → 0xFFFF_8899.
  - lhu → 0x0000_8899.
- sb 0x1001_0007, wdata 0x0000_0011 → `MemRead` 1 cycle, then `MemWrite` 1 cycle with `mem_addr`=0x1001_0004, `mem_wdata`=0x1199_AABB; `resp_valid` 2 cycles after accept.
- sw 0x1001_0008 = 0xDEAD_BEEF, then back-to-back lw 0x1001_0008 accepted on the `resp_valid` cycle → `resp_rdata`=0xDEAD_BEEF; `req_ready` low only during the STORE and LOAD cycles.
- Misaligned and illegal requests:
  - sh 0x1001_0005 → `misaligned_err`=1, `resp_rdata`=0, no `MemRead`/`MemWrite`, memory unchanged.
  - Same response for lw 0x1001_0002 and for size=11.
- Assert `reset`=0 asynchronously mid-cycle during RMW_WRITE of sb 0x1001_0004 → `MemWrite` drops immediately, word stays 0x8899_AABB, no `resp_valid`, `req_ready`=1.
- Request held with `req_valid`=1 while busy → accepted exactly once and executed once (single `MemWrite` pulse).
